// File: rtl/regfile_sb.sv
// Scoreboarded register file: NRD combinational read ports, two write-back ports, one issue reservation port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD-1:0]        re,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        rbusy,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  iss_ready,
   input  logic                  we0,
   input  logic [ADDR_W-1:0]     waddr0,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     waddr1,
   input  logic [DATA_W-1:0]     wdata1,
   input  logic                  flush,
   output logic [ADDR_W:0]       busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH - 1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_cnt;
   logic [DEPTH-1:0]  w_busy_wr;
   logic [DEPTH-1:0]  w_busy_nxt;
   logic              w_wr0;
   logic              w_wr1;
   logic              w_iss_ok;

   function automatic logic [ADDR_W:0] f_popcnt(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++)
         c = c + {{ADDR_W{1'b0}}, v[i]};
      return c;
   endfunction

   function automatic logic [ADDR_W:0] f_sat_cnt(input logic [ADDR_W:0] c);
      return (c > CNT_MAX) ? CNT_MAX : c;
   endfunction

   assign w_wr0 = we0 && (waddr0 != '0);
   assign w_wr1 = we1 && (waddr1 != '0);

   // A register written this cycle counts as free for issue; flush beats issue.
   always_comb begin
      w_busy_wr = r_busy;
      if (w_wr0) w_busy_wr[waddr0] = 1'b0;
      if (w_wr1) w_busy_wr[waddr1] = 1'b0;
      w_iss_ok   = iss_valid && !flush && !rst && !w_busy_wr[iss_addr];
      w_busy_nxt = w_busy_wr;
      if (flush)
         w_busy_nxt = '0;
      else if (w_iss_ok && (iss_addr != '0))
         w_busy_nxt[iss_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   assign iss_ready = w_iss_ok;
   assign busy_cnt  = r_busy_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= f_sat_cnt(f_popcnt(w_busy_nxt));
      end
   end

   // Port 1 is written last so it wins on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_wr0) r_mem[waddr0] <= wdata0;
         if (w_wr1) r_mem[waddr1] <= wdata1;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit;
      assign w_ra  = raddr[g*ADDR_W +: ADDR_W];
      assign w_hit = !rst && re[g] && (w_ra != '0);
`ifdef REGFILE_BYPASS_EN
      logic w_byp0;
      logic w_byp1;
      assign w_byp0 = w_wr0 && (waddr0 == w_ra);
      assign w_byp1 = w_wr1 && (waddr1 == w_ra);
      assign rdata[g*DATA_W +: DATA_W] = !w_hit ? '0     :
                                         w_byp1 ? wdata1 :
                                         w_byp0 ? wdata0 : r_mem[w_ra];
      assign rbusy[g] = w_hit && r_busy[w_ra] && !w_byp0 && !w_byp1;
`else
      assign rdata[g*DATA_W +: DATA_W] = w_hit ? r_mem[w_ra] : '0;
      assign rbusy[g] = w_hit && r_busy[w_ra];
`endif
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb (default parameters), with hand sequences for saturation and reset.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  re;
   logic [4:0]  ra0, ra1;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        iss_ready;
   logic        we0, we1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic        flush;
   logic [5:0]  busy_cnt;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .rst(rst), .re(re), .raddr({ra1, ra0}), .rdata(rdata), .rbusy(rbusy),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .flush(flush), .busy_cnt(busy_cnt)
   );

   typedef struct {
      logic        iv;
      logic [4:0]  ia;
      logic        fl;
      logic        w0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [1:0]  re;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
      logic        eir;
      logic [5:0]  ecnt;
   } vec_t;

   vec_t tv [24];

   function automatic vec_t mk(input logic iv, input logic [4:0] ia, input logic fl,
                               input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [1:0] r, input logic [4:0] r0, input logic [4:0] r1,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
                               input logic eir, input logic [5:0] ecnt);
      vec_t v;
      v.iv = iv; v.ia = ia; v.fl = fl;
      v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.re = r; v.r0 = r0; v.r1 = r1;
      v.e0 = e0; v.e1 = e1; v.eb = eb; v.eir = eir; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      re = 2'b00; ra0 = '0; ra1 = '0;
   endtask

   initial begin
      //            iv ia  fl w0 a0  d0       w1 a1  d1       re     r0  r1  e0                         e1       eb                 eir cnt
      tv[0]  = mk(1, 5,  0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  0);
      tv[1]  = mk(1, 5,  0, 0, 0,  0,       0, 0,  0,       2'b01, 5,  0,  0,                         0,       2'b01,             0,  1);
      tv[2]  = mk(0, 0,  0, 1, 5,  'h1234,  0, 0,  0,       2'b01, 5,  0,  BYP ? 32'h1234 : 32'h0,    0,       BYP ? 2'b00 : 2'b01, 0, 1);
      tv[3]  = mk(0, 0,  0, 0, 0,  0,       0, 0,  0,       2'b11, 5,  0,  'h1234,                    0,       2'b00,             0,  0);
      tv[4]  = mk(0, 0,  0, 1, 7,  'hAAAA,  1, 7,  'h5555,  2'b01, 7,  0,  BYP ? 32'h5555 : 32'h0,    0,       2'b00,             0,  0);
      tv[5]  = mk(0, 0,  0, 0, 0,  0,       0, 0,  0,       2'b10, 0,  7,  0,                         'h5555,  2'b00,             0,  0);
      tv[6]  = mk(1, 3,  0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  0);
      tv[7]  = mk(1, 3,  0, 0, 0,  0,       1, 3,  'hBEEF,  2'b01, 3,  0,  BYP ? 32'hBEEF : 32'h0,    0,       BYP ? 2'b00 : 2'b01, 1, 1);
      tv[8]  = mk(0, 0,  0, 0, 0,  0,       0, 0,  0,       2'b01, 3,  0,  'hBEEF,                    0,       2'b01,             0,  1);
      tv[9]  = mk(1, 1,  0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  1);
      tv[10] = mk(1, 2,  0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  2);
      tv[11] = mk(1, 9,  0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  3);
      tv[12] = mk(1, 4,  1, 0, 0,  0,       0, 0,  0,       2'b11, 9,  1,  0,                         0,       2'b11,             0,  4);
      tv[13] = mk(0, 0,  0, 1, 0,  'hFFFF,  0, 0,  0,       2'b11, 0,  9,  0,                         0,       2'b00,             0,  0);
      tv[14] = mk(1, 0,  0, 0, 0,  0,       0, 0,  0,       2'b11, 0,  4,  0,                         0,       2'b00,             1,  0);
      tv[15] = mk(1, 0,  0, 0, 0,  0,       0, 0,  0,       2'b01, 0,  0,  0,                         0,       2'b00,             1,  0);
      tv[16] = mk(1, 10, 0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  0);
      tv[17] = mk(1, 11, 0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  1);
      tv[18] = mk(0, 0,  0, 1, 10, 1,       1, 11, 2,       2'b00, 0,  0,  0,                         0,       2'b00,             0,  2);
      tv[19] = mk(0, 0,  0, 0, 0,  0,       0, 0,  0,       2'b11, 10, 11, 1,                         2,       2'b00,             0,  0);
      tv[20] = mk(1, 12, 0, 0, 0,  0,       0, 0,  0,       2'b00, 0,  0,  0,                         0,       2'b00,             1,  0);
      tv[21] = mk(0, 0,  0, 1, 12, 3,       1, 12, 4,       2'b00, 0,  0,  0,                         0,       2'b00,             0,  1);
      tv[22] = mk(0, 0,  0, 0, 0,  0,       0, 0,  0,       2'b01, 12, 0,  4,                         0,       2'b00,             0,  0);
      tv[23] = mk(0, 0,  0, 0, 0,  0,       0, 0,  0,       2'b00, 12, 0,  0,                         0,       2'b00,             0,  0);

      idle();
      rst = 1'b1;
      iss_valid = 1'b1; iss_addr = 5'd5; re = 2'b11; ra0 = 5'd5; ra1 = 5'd6;
      #2;
      chk("rst_rdata", rdata[31:0] | rdata[63:32], 32'h0);
      chk("rst_rbusy", {30'h0, rbusy}, 32'h0);
      chk("rst_iss_ready", {31'h0, iss_ready}, 32'h0);
      chk("rst_busy_cnt", {26'h0, busy_cnt}, 32'h0);
      @(negedge clk);
      idle();
      rst = 1'b0;

      for (int a = 0; a < 32; a++) begin
         re = 2'b11; ra0 = 5'(a); ra1 = 5'(31 - a);
         #1;
         chk($sformatf("init_rd0_a%0d", a), rdata[31:0], 32'h0);
         chk($sformatf("init_rd1_a%0d", a), rdata[63:32], 32'h0);
         chk($sformatf("init_rbusy_a%0d", a), {30'h0, rbusy}, 32'h0);
      end
      chk("init_busy_cnt", {26'h0, busy_cnt}, 32'h0);

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         iss_valid = tv[i].iv; iss_addr = tv[i].ia; flush = tv[i].fl;
         we0 = tv[i].w0; waddr0 = tv[i].a0; wdata0 = tv[i].d0;
         we1 = tv[i].w1; waddr1 = tv[i].a1; wdata1 = tv[i].d1;
         re = tv[i].re; ra0 = tv[i].r0; ra1 = tv[i].r1;
         #1;
         chk($sformatf("v%0d_rdata0", i), rdata[31:0], tv[i].e0);
         chk($sformatf("v%0d_rdata1", i), rdata[63:32], tv[i].e1);
         chk($sformatf("v%0d_rbusy", i), {30'h0, rbusy}, {30'h0, tv[i].eb});
         chk($sformatf("v%0d_iss_ready", i), {31'h0, iss_ready}, {31'h0, tv[i].eir});
         chk($sformatf("v%0d_busy_cnt", i), {26'h0, busy_cnt}, {26'h0, tv[i].ecnt});
      end
      @(negedge clk);
      idle();

      // Fill every reservable register; the count must stop at 31.
      for (int a = 1; a < 32; a++) begin
         @(negedge clk);
         iss_valid = 1'b1; iss_addr = 5'(a);
         #1;
         chk($sformatf("fill_iss_ready_r%0d", a), {31'h0, iss_ready}, 32'h1);
      end
      @(negedge clk);
      iss_valid = 1'b1; iss_addr = 5'd7;
      #1;
      chk("full_iss_ready", {31'h0, iss_ready}, 32'h0);
      chk("full_busy_cnt", {26'h0, busy_cnt}, 32'd31);
      @(negedge clk);
      iss_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_busy_cnt", {26'h0, busy_cnt}, 32'h0);

      // Reset asserted mid-cycle while a write is in flight.
      @(negedge clk);
      iss_valid = 1'b1; iss_addr = 5'd6;
      @(negedge clk);
      iss_valid = 1'b0;
      we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h77;
      re = 2'b01; ra0 = 5'd5;
      #1;
      chk("pre_rst_rd_r5", rdata[31:0], 32'h1234);
      chk("pre_rst_busy_cnt", {26'h0, busy_cnt}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_busy_cnt", {26'h0, busy_cnt}, 32'h0);
      chk("async_rst_rdata", rdata[31:0], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      re = 2'b11; ra0 = 5'd6; ra1 = 5'd5;
      #1;
      chk("post_rst_r6", rdata[31:0], 32'h0);
      chk("post_rst_r5", rdata[63:32], 32'h0);
      chk("post_rst_rbusy", {30'h0, rbusy}, 32'h0);
      chk("post_rst_busy_cnt", {26'h0, busy_cnt}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port re  input  NRD  per-port read enable.
REQ-007 SHALL have port raddr  input  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rdata  output  NRD*DATA_W  read data, packed like raddr.
REQ-009 SHALL have port rbusy  output  NRD  read operand has a pending producer.
REQ-010 SHALL have port iss_valid  input  1  issue request that reserves a destination register.
REQ-011 SHALL have port iss_addr  input  ADDR_W  destination being reserved.
REQ-012 SHALL have port iss_ready  output  1  issue accepted this cycle.
REQ-013 SHALL have ports we0/waddr0/wdata0 and we1/waddr1/wdata1  input  1/ADDR_W/DATA_W  two write-back ports (0 = ALU, 1 = load).
REQ-014 SHALL have port flush  input  1  clear all busy bits (pipeline squash).
REQ-015 SHALL have port busy_cnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-016 Register 0 SHALL always read zero, never be written, never be busy; iss_addr=0 SHALL be accepted with no state change.
REQ-017 Reads SHALL be combinational: rdata[i]=0 when rst, re[i]=0, or raddr[i]=0; otherwise stored value (subject to REQ-021).
REQ-018 Write: weK=1 and waddrK!=0 SHALL store wdataK at the clock edge; if both ports target the same address, port 1 SHALL win.
REQ-019 Each write SHALL clear the busy bit of its address at the same edge.
REQ-020 iss_ready SHALL be 1 iff iss_valid=1, flush=0, and busy[iss_addr]=0 after considering same-cycle writes (a register being written this cycle counts as free); accepted issue SHALL set busy[iss_addr] at the edge; issue set SHALL override a same-cycle write clear of the same address.
REQ-021 rbusy[i] SHALL be busy[raddr[i]] & re[i], deasserted for address 0 (modified per REQ-027/028).
REQ-022 flush=1 SHALL clear every busy bit at the edge, take priority over issue, and SHALL NOT block writes.
REQ-023 busy_cnt SHALL be a registered count equal to the population of busy bits, updated each edge consistently with REQ-019..022 (set +1, clears -1 each, no double count when both ports hit one address, flush -> 0).
REQ-024 No wrap: busy_cnt SHALL never exceed 2**ADDR_W-1.

Reset
REQ-025 rst=1 SHALL asynchronously zero all registers, all busy bits and busy_cnt; while rst=1, rdata=0, rbusy=0, iss_ready=0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight issue or write of that cycle.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: a read of an address written in the same cycle SHALL return that write data (port 1 priority) with rbusy[i]=0.
REQ-028 REGFILE_BYPASS_EN undefined: same-cycle reads SHALL return the old stored value and rbusy[i] SHALL remain as busy[raddr[i]]; new value visible the following cycle.

Verification
REQ-029 Reset release, read all 32 addresses on both ports -> rdata=0, rbusy=0, busy_cnt=0.
REQ-030 Issue r5, next cycle read r5 -> rbusy=1, busy_cnt=1; second issue r5 -> iss_ready=0; we0 r5=0x1234 -> next cycle rbusy=0, busy_cnt=0, rdata=0x1234.
REQ-031 Same cycle we0 r7=0xAAAA and we1 r7=0x5555 with read r7 -> bypass build: rdata=0x5555 that cycle; non-bypass: old value that cycle, 0x5555 next cycle.
REQ-032 Issue r3 and we1 r3 same cycle -> r3 holds write data, busy[3]=1, busy_cnt unchanged net +0 from prior busy state.
REQ-033 Busy r1,r2,r9 then flush with iss_valid r4 -> iss_ready=0, busy_cnt=0 next cycle; write r0=0xFFFF -> r0 reads 0.
REQ-034 Assert rst mid-cycle during we0 r6=0x77 -> r6 reads 0 after release, busy_cnt=0.
